// File: rtl/cd_dma.sv
// CD-system DMA: copies the sector cache (or a fill word) into 68k memory as
// 16-bit writes, owning the nBR/nBG/nBGACK bus handshake for the duration.
module cd_dma #(
  parameter int CACHE_AW = 11
) (
  input  logic                clk_sys,
  input  logic                nRESET,
  input  logic                START,
  input  logic [1:0]          MODE,
  input  logic [CACHE_AW-1:0] SRC_ADDR,
  input  logic [22:0]         DEST_ADDR,
  input  logic [15:0]         FILL_VALUE,
  input  logic [19:0]         WORD_COUNT,
  output logic [CACHE_AW-1:0] CACHE_ADDR,
  input  logic [7:0]          CACHE_DOUT,
  output logic                nBR,
  input  logic                nBG,
  output logic                nBGACK,
  input  logic                nAS,
  output logic                MEM_WR,
  output logic [22:0]         MEM_ADDR,
  output logic [15:0]         MEM_DATA,
  input  logic                MEM_READY,
  output logic                BUSY,
  output logic                DONE
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_REQ     = 4'd1;
  localparam logic [3:0] S_WAITAS  = 4'd2;
  localparam logic [3:0] S_FETCH   = 4'd3;
  localparam logic [3:0] S_FETCH2  = 4'd4;
  localparam logic [3:0] S_FETCH3  = 4'd5;
  localparam logic [3:0] S_WRITE   = 4'd6;
  localparam logic [3:0] S_RELEASE = 4'd7;
  localparam logic [3:0] S_FINISH  = 4'd8;

  logic [3:0]          state;
  logic                start_q;
  logic                trig_q;
  logic                fill_mode;
  logic [15:0]         fill_r;
  logic [CACHE_AW-1:0] ptr;
  logic [22:0]         dest;
  logic [19:0]         count;

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      trig_q     <= 1'b0;
      fill_mode  <= 1'b0;
      fill_r     <= '0;
      ptr        <= '0;
      dest       <= '0;
      count      <= '0;
      CACHE_ADDR <= '0;
      nBR        <= 1'b1;
      nBGACK     <= 1'b1;
      MEM_WR     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DATA   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      start_q <= START;
      trig_q  <= START & ~start_q;
      DONE    <= 1'b0;
      case (state)
        S_IDLE: begin
          BUSY <= 1'b0;
          // trig_q is only honoured here, so edges during a transfer are dropped
          if (trig_q) begin
            BUSY      <= 1'b1;
            fill_mode <= MODE[0];
            fill_r    <= FILL_VALUE;
            ptr       <= SRC_ADDR & ~CACHE_AW'(1);
            dest      <= DEST_ADDR;
            count     <= WORD_COUNT;
            if (WORD_COUNT == 20'd0 || MODE[1]) begin
              state <= S_FINISH;
            end else begin
              state <= S_REQ;
              nBR   <= 1'b0;
            end
          end
        end
        S_REQ: if (!nBG) state <= S_WAITAS;
        S_WAITAS: begin
          // take the bus only once the 68k has finished its current cycle
          if (nAS) begin
            nBGACK <= 1'b0;
            nBR    <= 1'b1;
            if (fill_mode) begin
              state    <= S_WRITE;
              MEM_WR   <= 1'b1;
              MEM_ADDR <= dest;
              MEM_DATA <= fill_r;
            end else begin
              state      <= S_FETCH;
              CACHE_ADDR <= ptr;
            end
          end
        end
        S_FETCH: begin
          CACHE_ADDR <= ptr | CACHE_AW'(1);
          state      <= S_FETCH2;
        end
        S_FETCH2: begin
          MEM_DATA[15:8] <= CACHE_DOUT;
          state          <= S_FETCH3;
        end
        S_FETCH3: begin
          MEM_DATA[7:0] <= CACHE_DOUT;
          ptr           <= ptr + CACHE_AW'(2);
          MEM_WR        <= 1'b1;
          MEM_ADDR      <= dest;
          state         <= S_WRITE;
        end
        S_WRITE: begin
          if (MEM_READY) begin
            dest  <= dest + 23'd1;
            count <= count - 20'd1;
            if (count == 20'd1) begin
              MEM_WR <= 1'b0;
              state  <= S_RELEASE;
            end else if (fill_mode) begin
              MEM_ADDR <= dest + 23'd1;
            end else begin
              MEM_WR     <= 1'b0;
              CACHE_ADDR <= ptr;
              state      <= S_FETCH;
            end
          end
        end
        S_RELEASE: begin
          nBGACK <= 1'b1;
          state  <= S_FINISH;
        end
        S_FINISH: begin
          DONE  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cd_dma.sv
// Directed bench for cd_dma: cache model, bus-grant handshake driven from tasks,
// a write monitor recording every accepted word.
module tb_cd_dma;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic        START;
  logic [1:0]  MODE;
  logic [10:0] SRC_ADDR;
  logic [22:0] DEST_ADDR;
  logic [15:0] FILL_VALUE;
  logic [19:0] WORD_COUNT;
  logic [10:0] CACHE_ADDR;
  logic [7:0]  CACHE_DOUT;
  logic        nBR, nBG, nBGACK, nAS;
  logic        MEM_WR, MEM_READY, BUSY, DONE;
  logic [22:0] MEM_ADDR;
  logic [15:0] MEM_DATA;

  cd_dma #(.CACHE_AW(11)) dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .START(START), .MODE(MODE),
    .SRC_ADDR(SRC_ADDR), .DEST_ADDR(DEST_ADDR), .FILL_VALUE(FILL_VALUE),
    .WORD_COUNT(WORD_COUNT), .CACHE_ADDR(CACHE_ADDR), .CACHE_DOUT(CACHE_DOUT),
    .nBR(nBR), .nBG(nBG), .nBGACK(nBGACK), .nAS(nAS), .MEM_WR(MEM_WR),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0]  cache_mem [0:2047];
  always @(posedge clk_sys) CACHE_DOUT <= cache_mem[CACHE_ADDR];

  logic [22:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          cyc = 0, done_cnt = 0, nbr_cnt = 0, memwr_cnt = 0;
  int          n_chk = 0, n_fail = 0;

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (MEM_WR && MEM_READY) begin
      wr_addr.push_back(MEM_ADDR);
      wr_data.push_back(MEM_DATA);
      wr_cyc.push_back(cyc);
    end
    if (DONE)    done_cnt  <= done_cnt + 1;
    if (!nBR)    nbr_cnt   <= nbr_cnt + 1;
    if (MEM_WR)  memwr_cnt <= memwr_cnt + 1;
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_xfer(input logic [1:0] m, input logic [10:0] s, input logic [22:0] d,
                            input logic [15:0] f, input logic [19:0] c);
    MODE = m; SRC_ADDR = s; DEST_ADDR = d; FILL_VALUE = f; WORD_COUNT = c;
    START = 1'b1;
    tick;
    START = 1'b0;
  endtask

  task automatic grant_bus(input int dly);
    int i;
    for (i = 0; i < 50 && nBR !== 1'b0; i++) tick;
    n_chk++;
    if (nBR !== 1'b0) begin n_fail++; $display("FAIL grant_req: nBR=%b after 50 cycles, want 0", nBR); end
    repeat (dly) tick;
    nBG = 1'b0;
    for (i = 0; i < 50 && nBGACK !== 1'b0; i++) tick;
    n_chk++;
    if (nBGACK !== 1'b0 || nBR !== 1'b1) begin
      n_fail++; $display("FAIL grant_ack: nBGACK=%b nBR=%b, want 0/1", nBGACK, nBR);
    end
    nBG = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && DONE !== 1'b1; i++) tick;
    n_chk++;
    if (DONE !== 1'b1 || nBGACK !== 1'b1 || MEM_WR !== 1'b0) begin
      n_fail++; $display("FAIL done_seen: DONE=%b nBGACK=%b MEM_WR=%b, want 1/1/0", DONE, nBGACK, MEM_WR);
    end
    tick;
    n_chk++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL busy_fall: BUSY=%b DONE=%b after done, want 0/0", BUSY, DONE);
    end
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    repeat (2) tick;
    n_chk++;
    if (nBR !== 1'b1 || nBGACK !== 1'b1 || MEM_WR !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: nBR=%b nBGACK=%b MEM_WR=%b BUSY=%b DONE=%b, want 1 1 0 0 0",
                         nBR, nBGACK, MEM_WR, BUSY, DONE);
    end
    n_chk++;
    if (MEM_ADDR !== 23'h0 || MEM_DATA !== 16'h0 || CACHE_ADDR !== 11'h0) begin
      n_fail++; $display("FAIL reset_bus: MEM_ADDR=%h MEM_DATA=%h CACHE_ADDR=%h, want 0",
                         MEM_ADDR, MEM_DATA, CACHE_ADDR);
    end
    nRESET = 1'b1;
    tick;
  endtask

  task automatic test_mode0;
    int w0 = wr_addr.size();
    int d0 = done_cnt;
    start_xfer(2'd0, 11'h010, 23'h100000, 16'h0000, 20'd4);
    n_chk++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL m0_busy_early: BUSY=%b, want 0", BUSY); end
    tick;
    n_chk++;
    if (BUSY !== 1'b1 || nBR !== 1'b0 || nBGACK !== 1'b1) begin
      n_fail++; $display("FAIL m0_req: BUSY=%b nBR=%b nBGACK=%b, want 1 0 1", BUSY, nBR, nBGACK);
    end
    grant_bus(3);
    wait_done(100);
    n_chk++;
    if (wr_addr.size() - w0 != 4) begin
      n_fail++; $display("FAIL m0_count: %0d writes, want 4", wr_addr.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [15:0] exp_d;
        exp_d = {8'(2 * i), 8'(2 * i + 1)};
        n_chk++;
        if (wr_addr[w0+i] !== 23'h100000 + 23'(i) || wr_data[w0+i] !== exp_d) begin
          n_fail++; $display("FAIL m0_word%0d: %h@%h, want %h@%h", i, wr_data[w0+i], wr_addr[w0+i],
                             exp_d, 23'h100000 + 23'(i));
        end
      end
      n_chk++;
      if (wr_cyc[w0+1] - wr_cyc[w0] != 4) begin
        n_fail++; $display("FAIL m0_rate: %0d cycles/word, want 4", wr_cyc[w0+1] - wr_cyc[w0]);
      end
    end
    n_chk++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL m0_done: %0d pulses, want 1", done_cnt - d0); end
  endtask

  task automatic test_fill_stall;
    int w0 = wr_addr.size();
    start_xfer(2'd1, 11'h000, 23'h7FFFFE, 16'hA55A, 20'd3);
    grant_bus(0);
    n_chk++;
    if (MEM_WR !== 1'b1 || MEM_ADDR !== 23'h7FFFFE) begin
      n_fail++; $display("FAIL fill_first: MEM_WR=%b MEM_ADDR=%h, want 1 7ffffe", MEM_WR, MEM_ADDR);
    end
    tick;
    MEM_READY = 1'b0;
    tick;
    n_chk++;
    if (MEM_WR !== 1'b1 || MEM_ADDR !== 23'h7FFFFF || MEM_DATA !== 16'hA55A) begin
      n_fail++; $display("FAIL fill_stall: MEM_WR=%b %h@%h, want 1 a55a@7fffff", MEM_WR, MEM_DATA, MEM_ADDR);
    end
    MEM_READY = 1'b1;
    wait_done(20);
    n_chk++;
    if (wr_addr.size() - w0 != 3) begin
      n_fail++; $display("FAIL fill_count: %0d writes, want 3", wr_addr.size() - w0);
    end else begin
      n_chk++;
      if (wr_addr[w0] !== 23'h7FFFFE || wr_addr[w0+1] !== 23'h7FFFFF || wr_addr[w0+2] !== 23'h000000 ||
          wr_data[w0] !== 16'hA55A || wr_data[w0+1] !== 16'hA55A || wr_data[w0+2] !== 16'hA55A) begin
        n_fail++; $display("FAIL fill_words: %h@%h %h@%h %h@%h, want a55a@7ffffe,7fffff,000000",
                           wr_data[w0], wr_addr[w0], wr_data[w0+1], wr_addr[w0+1], wr_data[w0+2], wr_addr[w0+2]);
      end
      n_chk++;
      if (wr_cyc[w0+2] - wr_cyc[w0+1] != 1) begin
        n_fail++; $display("FAIL fill_rate: %0d cycles/word, want 1", wr_cyc[w0+2] - wr_cyc[w0+1]);
      end
    end
  endtask

  task automatic test_wrap;
    int w0 = wr_addr.size();
    // odd source offset: bit 0 is dropped, so reading starts at 0x7FE
    start_xfer(2'd0, 11'h7FF, 23'h000200, 16'h0000, 20'd2);
    grant_bus(1);
    wait_done(60);
    n_chk++;
    if (wr_addr.size() - w0 != 2 || wr_data[w0] !== 16'hABCD || wr_data[w0+1] !== 16'h1234 ||
        wr_addr[w0+1] !== 23'h000201) begin
      n_fail++; $display("FAIL wrap: %0d writes %h %h@%h, want 2 abcd 1234@000201",
                         wr_addr.size() - w0, wr_data[w0], wr_data[w0+1], wr_addr[w0+1]);
    end
  endtask

  task automatic test_no_xfer(input logic [1:0] m, input logic [19:0] c);
    int d0 = done_cnt, b0 = nbr_cnt, m0 = memwr_cnt;
    start_xfer(m, 11'h000, 23'h000600, 16'h0000, c);
    n_chk++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL nox_early_m%0d: DONE=%b, want 0", m, DONE); end
    tick;
    n_chk++;
    if (DONE !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL nox_finish_m%0d: DONE=%b BUSY=%b, want 0 1", m, DONE, BUSY);
    end
    tick;
    n_chk++;
    if (DONE !== 1'b1) begin n_fail++; $display("FAIL nox_done_m%0d: DONE=%b, want 1", m, DONE); end
    tick;
    n_chk++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL nox_end_m%0d: DONE=%b BUSY=%b pulses=%0d, want 0 0 1", m, DONE, BUSY, done_cnt - d0);
    end
    n_chk++;
    if (nbr_cnt != b0 || memwr_cnt != m0) begin
      n_fail++; $display("FAIL nox_bus_m%0d: nBR low %0d cycles, MEM_WR high %0d cycles, want 0 0",
                         m, nbr_cnt - b0, memwr_cnt - m0);
    end
  endtask

  task automatic test_nas_hold;
    int w0 = wr_addr.size();
    int d0 = done_cnt;
    nAS = 1'b0;
    start_xfer(2'd1, 11'h000, 23'h000300, 16'h1111, 20'd2);
    tick;
    nBG = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (k == 1) START = 1'b1;
      if (k == 3) START = 1'b0;
      n_chk++;
      if (nBGACK !== 1'b1 || MEM_WR !== 1'b0) begin
        n_fail++; $display("FAIL nas_hold%0d: nBGACK=%b MEM_WR=%b, want 1 0", k, nBGACK, MEM_WR);
      end
    end
    nAS = 1'b1;
    for (int i = 0; i < 10 && nBGACK !== 1'b0; i++) tick;
    n_chk++;
    if (nBGACK !== 1'b0) begin n_fail++; $display("FAIL nas_ack: nBGACK=%b, want 0", nBGACK); end
    nBG = 1'b1;
    wait_done(20);
    repeat (5) tick;
    n_chk++;
    if (wr_addr.size() - w0 != 2 || wr_addr[w0+1] !== 23'h000301 || wr_data[w0+1] !== 16'h1111) begin
      n_fail++; $display("FAIL nas_words: %0d writes last %h@%h, want 2 1111@000301",
                         wr_addr.size() - w0, wr_data[w0+1], wr_addr[w0+1]);
    end
    n_chk++;
    if (done_cnt - d0 != 1 || BUSY !== 1'b0 || nBR !== 1'b1) begin
      n_fail++; $display("FAIL nas_restart: pulses=%0d BUSY=%b nBR=%b, want 1 0 1", done_cnt - d0, BUSY, nBR);
    end
  endtask

  task automatic test_reset_mid;
    int w0 = wr_addr.size();
    int d0 = done_cnt;
    start_xfer(2'd1, 11'h000, 23'h000400, 16'hBEEF, 20'd8);
    grant_bus(0);
    tick;
    n_chk++;
    if (MEM_WR !== 1'b1 || MEM_ADDR !== 23'h000401) begin
      n_fail++; $display("FAIL rst_word2: MEM_WR=%b MEM_ADDR=%h, want 1 000401", MEM_WR, MEM_ADDR);
    end
    #1 nRESET = 1'b0;
    #1;
    n_chk++;
    if (nBR !== 1'b1 || nBGACK !== 1'b1 || MEM_WR !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rst_abort: nBR=%b nBGACK=%b MEM_WR=%b BUSY=%b, want 1 1 0 0",
                         nBR, nBGACK, MEM_WR, BUSY);
    end
    repeat (3) tick;
    nRESET = 1'b1;
    tick;
    n_chk++;
    if (done_cnt != d0 || wr_addr.size() - w0 != 1) begin
      n_fail++; $display("FAIL rst_nodone: pulses=%0d writes=%0d, want 0 1", done_cnt - d0, wr_addr.size() - w0);
    end
    w0 = wr_addr.size();
    start_xfer(2'd0, 11'h010, 23'h000500, 16'h0000, 20'd1);
    grant_bus(1);
    wait_done(40);
    n_chk++;
    if (wr_addr.size() - w0 != 1 || wr_data[w0] !== 16'h0001 || wr_addr[w0] !== 23'h000500) begin
      n_fail++; $display("FAIL rst_rerun: %0d writes %h@%h, want 1 0001@000500",
                         wr_addr.size() - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) cache_mem[i] = 8'hEE;
    for (int i = 0; i < 8; i++) cache_mem[16 + i] = 8'(i);
    cache_mem[2046] = 8'hAB; cache_mem[2047] = 8'hCD;
    cache_mem[0] = 8'h12;    cache_mem[1] = 8'h34;
    START = 1'b0; MODE = 2'd0; SRC_ADDR = '0; DEST_ADDR = '0; FILL_VALUE = '0; WORD_COUNT = '0;
    nBG = 1'b1; nAS = 1'b1; MEM_READY = 1'b1;
    test_reset;
    test_mode0;
    test_fill_stall;
    test_wrap;
    test_no_xfer(2'd0, 20'd0);
    test_no_xfer(2'd2, 20'd5);
    test_nas_hold;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
